// File: rtl/ram_arb.sv
// ram_arb: two-requester arbiter for a single RAM port.
//
// One requester does instruction fetch and the other does load/store. Each
// one has a valid/ready request channel and a valid/ready response channel.
// Only one transaction is in flight at a time. When both requesters are
// valid on the same cycle, the one that was not granted last time wins.
// The RAM read port is combinational, and its data is captured into the
// response register at the end of the grant cycle. A store reaches the RAM
// at that same edge.
// A misaligned request never touches memory. It is answered with err = 1
// and data = 0.
//
// Ports:
//   i_sys_clk, i_sys_rst              clock, synchronous active-high reset
//   i_inst_req_* / o_inst_req_ready   fetch request channel
//   o_inst_rsp_* / i_inst_rsp_ready   fetch response channel
//   i_data_req_* / o_data_req_ready   load/store request channel
//   o_data_rsp_* / i_data_rsp_ready   load/store response channel
//   o_mem_rd_*, i_mem_rd_data         RAM read port (combinational data)
//   o_mem_wr_*                        RAM byte-masked write port
module ram_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic                    i_inst_req_valid,
  output logic                    o_inst_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_inst_req_addr,
  output logic                    o_inst_rsp_valid,
  input  logic                    i_inst_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_inst_rsp_data,
  output logic                    o_inst_rsp_err,
  input  logic                    i_data_req_valid,
  output logic                    o_data_req_ready,
  input  logic                    i_data_req_wen,
  input  logic [ADDR_WIDTH-1:0]   i_data_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_data_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_data_req_mask,
  output logic                    o_data_rsp_valid,
  input  logic                    i_data_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_data_rsp_data,
  output logic                    o_data_rsp_err,
  output logic                    o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   i_mem_rd_data,
  output logic                    o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_mem_wr_mask
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  // The byte-offset bits of an address. Any 1 here means the address is misaligned.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(MASK_WIDTH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_owner;       // 0 = inst, 1 = data
  logic                  r_last_grant;  // 0 = inst, 1 = data
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;

  logic                  w_grant;
  logic                  w_winner;      // 0 = inst, 1 = data
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic                  w_req_wen;
  logic                  w_misaligned;
  logic                  w_rd_en;
  logic                  w_wr_en;
  logic                  w_owner_rsp_ready;
  logic                  w_rsp_valid;

  // Arbitration. This only happens in IDLE, and reset blocks any handshake.
  always_comb begin
    w_grant  = 1'b0;
    w_winner = 1'b0;
    if ((r_state == ST_IDLE) && !i_sys_rst) begin
      if (i_inst_req_valid && i_data_req_valid) begin
        w_grant  = 1'b1;
        w_winner = ~r_last_grant;
      end else if (i_inst_req_valid) begin
        w_grant  = 1'b1;
        w_winner = 1'b0;
      end else if (i_data_req_valid) begin
        w_grant  = 1'b1;
        w_winner = 1'b1;
      end else begin
        w_grant  = 1'b0;
        w_winner = 1'b0;
      end
    end else begin
      w_grant  = 1'b0;
      w_winner = 1'b0;
    end
  end

  // Pick the winner's request and decode what it does to memory.
  always_comb begin
    w_req_addr   = w_winner ? i_data_req_addr : i_inst_req_addr;
    w_req_wen    = w_winner & i_data_req_wen;
    w_misaligned = (w_req_addr & ALIGN_MASK) != {ADDR_WIDTH{1'b0}};
    w_rd_en      = w_grant & ~w_misaligned & ~w_req_wen;
    w_wr_en      = w_grant & ~w_misaligned & w_req_wen;
  end

  // Memory ports. Any field that is not enabled is forced to 0.
  always_comb begin
    o_mem_rd_en   = w_rd_en;
    o_mem_rd_addr = w_rd_en ? w_req_addr : {ADDR_WIDTH{1'b0}};
    o_mem_wr_en   = w_wr_en;
    o_mem_wr_addr = w_wr_en ? w_req_addr : {ADDR_WIDTH{1'b0}};
    o_mem_wr_data = w_wr_en ? i_data_req_wdata : {DATA_WIDTH{1'b0}};
    o_mem_wr_mask = w_wr_en ? i_data_req_mask : {MASK_WIDTH{1'b0}};
  end

  // Request ready and response channels.
  // Ready depends only on state and the valids, never on rsp_ready.
  always_comb begin
    o_inst_req_ready = w_grant & ~w_winner;
    o_data_req_ready = w_grant & w_winner;
    w_rsp_valid      = (r_state == ST_RESP);
    o_inst_rsp_valid = w_rsp_valid & ~r_owner;
    o_data_rsp_valid = w_rsp_valid & r_owner;
    o_inst_rsp_data  = o_inst_rsp_valid ? r_rsp_data : {DATA_WIDTH{1'b0}};
    o_inst_rsp_err   = o_inst_rsp_valid & r_rsp_err;
    o_data_rsp_data  = o_data_rsp_valid ? r_rsp_data : {DATA_WIDTH{1'b0}};
    o_data_rsp_err   = o_data_rsp_valid & r_rsp_err;
  end

  // Next-state logic.
  always_comb begin
    w_owner_rsp_ready = r_owner ? i_data_rsp_ready : i_inst_rsp_ready;
    w_state_next      = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_next = ST_RESP;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (w_owner_rsp_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RESP;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register and response capture.
  // Reset overrides any handshake on the same cycle.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_data   <= {DATA_WIDTH{1'b0}};
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
        r_rsp_data   <= w_rd_en ? i_mem_rd_data : {DATA_WIDTH{1'b0}};
        r_rsp_err    <= w_misaligned;
      end else begin
        r_owner      <= r_owner;
        r_last_grant <= r_last_grant;
        r_rsp_data   <= r_rsp_data;
        r_rsp_err    <= r_rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: directed self-checking bench for ram_arb.
// It uses a small behavioural RAM with a combinational read and a
// byte-masked write on the clock edge.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// after the falling edge.
module tb_ram_arb;

  logic        clk;
  logic        rst;
  logic        inst_req_valid, inst_req_ready;
  logic [31:0] inst_req_addr;
  logic        inst_rsp_valid, inst_rsp_ready;
  logic [31:0] inst_rsp_data;
  logic        inst_rsp_err;
  logic        data_req_valid, data_req_ready, data_req_wen;
  logic [31:0] data_req_addr, data_req_wdata;
  logic [3:0]  data_req_mask;
  logic        data_rsp_valid, data_rsp_ready;
  logic [31:0] data_rsp_data;
  logic        data_rsp_err;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
  logic [3:0]  mem_wr_mask;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:1023];
  logic        load_en = 1'b0;
  logic [9:0]  load_idx = 10'd0;
  logic [31:0] load_val = 32'd0;

  ram_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_inst_req_valid(inst_req_valid), .o_inst_req_ready(inst_req_ready),
    .i_inst_req_addr(inst_req_addr),
    .o_inst_rsp_valid(inst_rsp_valid), .i_inst_rsp_ready(inst_rsp_ready),
    .o_inst_rsp_data(inst_rsp_data), .o_inst_rsp_err(inst_rsp_err),
    .i_data_req_valid(data_req_valid), .o_data_req_ready(data_req_ready),
    .i_data_req_wen(data_req_wen), .i_data_req_addr(data_req_addr),
    .i_data_req_wdata(data_req_wdata), .i_data_req_mask(data_req_mask),
    .o_data_rsp_valid(data_rsp_valid), .i_data_rsp_ready(data_rsp_ready),
    .o_data_rsp_data(data_rsp_data), .o_data_rsp_err(data_rsp_err),
    .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr),
    .i_mem_rd_data(mem_rd_data),
    .o_mem_wr_en(mem_wr_en), .o_mem_wr_addr(mem_wr_addr),
    .o_mem_wr_data(mem_wr_data), .o_mem_wr_mask(mem_wr_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_rd_addr[11:2]];

  // RAM model: bench preload, otherwise a byte-masked write.
  always @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_val;
    end else if (mem_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_mask[b]) mem[mem_wr_addr[11:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end
    end
  end

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    @(negedge clk);
    load_en = 1'b1; load_idx = idx; load_val = val;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic clear_inputs();
    inst_req_valid = 1'b0; inst_req_addr = 32'd0; inst_rsp_ready = 1'b0;
    data_req_valid = 1'b0; data_req_wen = 1'b0; data_req_addr = 32'd0;
    data_req_wdata = 32'd0; data_req_mask = 4'd0; data_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    preload(10'h040, 32'h0000_0013);   // addr 0x100
    preload(10'h080, 32'h1122_3344);   // addr 0x200
    @(negedge clk); #1;
    n_checks++; if ({inst_rsp_valid, data_rsp_valid} !== 2'b00) begin n_errors++; $display("FAIL reset_rsp_valid: got %b expected 00", {inst_rsp_valid, data_rsp_valid}); end
    n_checks++; if ({inst_req_ready, data_req_ready} !== 2'b00) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 00", {inst_req_ready, data_req_ready}); end
    n_checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin n_errors++; $display("FAIL reset_mem_en: got %b expected 00", {mem_rd_en, mem_wr_en}); end
    n_checks++; if (inst_rsp_data !== 32'd0 || data_rsp_data !== 32'd0) begin n_errors++; $display("FAIL reset_rsp_data: got %h/%h expected 0/0", inst_rsp_data, data_rsp_data); end
    n_checks++; if (mem_rd_addr !== 32'd0 || mem_wr_addr !== 32'd0 || mem_wr_data !== 32'd0 || mem_wr_mask !== 4'd0) begin n_errors++; $display("FAIL reset_mem_bus: got %h %h %h %h expected zeros", mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_mask); end
    // Reset must win over a request that is valid at the same time.
    inst_req_valid = 1'b1; inst_req_addr = 32'h100; #1;
    n_checks++; if (inst_req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_blocks_grant: got %b expected 0", inst_req_ready); end
    @(posedge clk); @(negedge clk);
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    inst_req_valid = 1'b1; inst_req_addr = 32'h100; #1;
    n_checks++; if (inst_req_ready !== 1'b1 || data_req_ready !== 1'b0) begin n_errors++; $display("FAIL fetch_ready: got %b%b expected 10", inst_req_ready, data_req_ready); end
    n_checks++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'h100) begin n_errors++; $display("FAIL fetch_rd_port: got %b %h expected 1 00000100", mem_rd_en, mem_rd_addr); end
    @(posedge clk); @(negedge clk);
    inst_req_valid = 1'b0; inst_rsp_ready = 1'b1; #1;
    n_checks++; if (inst_rsp_valid !== 1'b1 || data_rsp_valid !== 1'b0) begin n_errors++; $display("FAIL fetch_rsp_valid: got %b%b expected 10", inst_rsp_valid, data_rsp_valid); end
    n_checks++; if (inst_rsp_data !== 32'h0000_0013 || inst_rsp_err !== 1'b0) begin n_errors++; $display("FAIL fetch_rsp_data: got %h err %b expected 00000013 err 0", inst_rsp_data, inst_rsp_err); end
    @(posedge clk); @(negedge clk);
    inst_rsp_ready = 1'b0; #1;
    n_checks++; if (inst_rsp_valid !== 1'b0 || inst_rsp_data !== 32'd0) begin n_errors++; $display("FAIL fetch_rsp_done: got %b %h expected 0 0", inst_rsp_valid, inst_rsp_data); end
  endtask

  task automatic test_store_load();
    data_req_valid = 1'b1; data_req_wen = 1'b1; data_req_addr = 32'h200;
    data_req_wdata = 32'hAABB_CCDD; data_req_mask = 4'b0101; #1;
    n_checks++; if (data_req_ready !== 1'b1) begin n_errors++; $display("FAIL store_ready: got %b expected 1", data_req_ready); end
    n_checks++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0) begin n_errors++; $display("FAIL store_en: got wr %b rd %b expected wr 1 rd 0", mem_wr_en, mem_rd_en); end
    n_checks++; if (mem_wr_addr !== 32'h200 || mem_wr_data !== 32'hAABB_CCDD || mem_wr_mask !== 4'b0101) begin n_errors++; $display("FAIL store_wr_bus: got %h %h %b expected 00000200 aabbccdd 0101", mem_wr_addr, mem_wr_data, mem_wr_mask); end
    @(posedge clk); @(negedge clk);
    data_req_valid = 1'b0; data_req_wen = 1'b0; data_rsp_ready = 1'b1; #1;
    n_checks++; if (mem_wr_en !== 1'b0) begin n_errors++; $display("FAIL store_wr_pulse: got %b expected 0", mem_wr_en); end
    n_checks++; if (data_rsp_valid !== 1'b1 || data_rsp_data !== 32'd0 || data_rsp_err !== 1'b0) begin n_errors++; $display("FAIL store_rsp: got %b %h %b expected 1 00000000 0", data_rsp_valid, data_rsp_data, data_rsp_err); end
    @(posedge clk); @(negedge clk);
    data_req_valid = 1'b1; data_req_wen = 1'b0; data_req_addr = 32'h200; #1;
    n_checks++; if (data_req_ready !== 1'b1 || mem_rd_en !== 1'b1 || mem_rd_addr !== 32'h200) begin n_errors++; $display("FAIL load_grant: got %b %b %h expected 1 1 00000200", data_req_ready, mem_rd_en, mem_rd_addr); end
    @(posedge clk); @(negedge clk);
    data_req_valid = 1'b0; #1;
    n_checks++; if (data_rsp_valid !== 1'b1 || data_rsp_data !== 32'h11BB_33DD || data_rsp_err !== 1'b0) begin n_errors++; $display("FAIL load_rsp: got %b %h %b expected 1 11bb33dd 0", data_rsp_valid, data_rsp_data, data_rsp_err); end
    @(posedge clk); @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    inst_req_valid = 1'b1; inst_req_addr = 32'h100; inst_rsp_ready = 1'b1;
    data_req_valid = 1'b1; data_req_wen = 1'b0; data_req_addr = 32'h200; data_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++; if ({inst_req_ready, data_req_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL b2b_grant[%0d]: got %b%b expected %s", i, inst_req_ready, data_req_ready, (i % 2 == 0) ? "10" : "01"); end
      @(posedge clk); @(negedge clk); #1;
      n_checks++; if ({inst_req_ready, data_req_ready} !== 2'b00) begin n_errors++; $display("FAIL b2b_ready_resp[%0d]: got %b%b expected 00", i, inst_req_ready, data_req_ready); end
      n_checks++; if ({inst_rsp_valid, data_rsp_valid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL b2b_rsp_valid[%0d]: got %b%b", i, inst_rsp_valid, data_rsp_valid); end
      n_checks++; if ((i % 2 == 0) ? (inst_rsp_data !== 32'h13) : (data_rsp_data !== 32'h11BB_33DD)) begin n_errors++; $display("FAIL b2b_rsp_data[%0d]: got inst %h data %h", i, inst_rsp_data, data_rsp_data); end
      @(posedge clk); @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_misaligned();
    data_req_valid = 1'b1; data_req_wen = 1'b0; data_req_addr = 32'h203; #1;
    n_checks++; if (data_req_ready !== 1'b1) begin n_errors++; $display("FAIL misal_ready: got %b expected 1", data_req_ready); end
    n_checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin n_errors++; $display("FAIL misal_mem_en_grant: got %b expected 00", {mem_rd_en, mem_wr_en}); end
    @(posedge clk); @(negedge clk);
    data_req_valid = 1'b0; #1;
    n_checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin n_errors++; $display("FAIL misal_mem_en_resp: got %b expected 00", {mem_rd_en, mem_wr_en}); end
    n_checks++; if (data_rsp_valid !== 1'b1 || data_rsp_err !== 1'b1 || data_rsp_data !== 32'd0) begin n_errors++; $display("FAIL misal_rsp: got %b err %b %h expected 1 err 1 00000000", data_rsp_valid, data_rsp_err, data_rsp_data); end
    data_rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    clear_inputs(); #1;
    n_checks++; if (data_rsp_valid !== 1'b0 || data_rsp_err !== 1'b0) begin n_errors++; $display("FAIL misal_done: got %b %b expected 0 0", data_rsp_valid, data_rsp_err); end
  endtask

  task automatic test_backpressure();
    // The last grant went to data, so inst wins this tie.
    inst_req_valid = 1'b1; inst_req_addr = 32'h100;
    data_req_valid = 1'b1; data_req_wen = 1'b0; data_req_addr = 32'h200; #1;
    n_checks++; if ({inst_req_ready, data_req_ready} !== 2'b10) begin n_errors++; $display("FAIL bp_grant: got %b%b expected 10", inst_req_ready, data_req_ready); end
    @(posedge clk); @(negedge clk);
    inst_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (data_req_ready !== 1'b0 || mem_rd_en !== 1'b0) begin n_errors++; $display("FAIL bp_stall[%0d]: got ready %b rd_en %b expected 0 0", i, data_req_ready, mem_rd_en); end
      n_checks++; if (inst_rsp_valid !== 1'b1 || inst_rsp_data !== 32'h13) begin n_errors++; $display("FAIL bp_hold[%0d]: got %b %h expected 1 00000013", i, inst_rsp_valid, inst_rsp_data); end
      @(posedge clk); @(negedge clk);
    end
    inst_rsp_ready = 1'b1; #1;
    n_checks++; if (data_req_ready !== 1'b0) begin n_errors++; $display("FAIL bp_no_comb_path: got %b expected 0", data_req_ready); end
    @(posedge clk); @(negedge clk);
    inst_rsp_ready = 1'b0; #1;
    n_checks++; if (data_req_ready !== 1'b1 || inst_rsp_valid !== 1'b0) begin n_errors++; $display("FAIL bp_data_grant: got ready %b inst_rsp_valid %b expected 1 0", data_req_ready, inst_rsp_valid); end
    @(posedge clk); @(negedge clk);
    data_req_valid = 1'b0; data_rsp_ready = 1'b1; #1;
    n_checks++; if (data_rsp_valid !== 1'b1 || data_rsp_data !== 32'h11BB_33DD) begin n_errors++; $display("FAIL bp_data_rsp: got %b %h expected 1 11bb33dd", data_rsp_valid, data_rsp_data); end
    @(posedge clk); @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_in_resp();
    // Take inst into RESP. Without a reset, data would win the next tie.
    inst_req_valid = 1'b1; inst_req_addr = 32'h100;
    @(posedge clk); @(negedge clk);
    inst_req_valid = 1'b0; inst_rsp_ready = 1'b1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    inst_rsp_ready = 1'b0; #1;
    n_checks++; if ({inst_rsp_valid, data_rsp_valid} !== 2'b00 || inst_rsp_data !== 32'd0) begin n_errors++; $display("FAIL rst_resp_drop: got %b%b %h expected 00 0", inst_rsp_valid, data_rsp_valid, inst_rsp_data); end
    n_checks++; if ({inst_req_ready, data_req_ready, mem_rd_en, mem_wr_en} !== 4'b0000) begin n_errors++; $display("FAIL rst_resp_outputs: got %b expected 0000", {inst_req_ready, data_req_ready, mem_rd_en, mem_wr_en}); end
    rst = 1'b0;
    inst_req_valid = 1'b1; inst_req_addr = 32'h100;
    data_req_valid = 1'b1; data_req_addr = 32'h200; #1;
    n_checks++; if ({inst_req_ready, data_req_ready} !== 2'b10) begin n_errors++; $display("FAIL rst_tie_inst_first: got %b%b expected 10", inst_req_ready, data_req_ready); end
    @(posedge clk); @(negedge clk);
    clear_inputs(); #1;
    n_checks++; if (inst_rsp_valid !== 1'b1 || inst_rsp_data !== 32'h13) begin n_errors++; $display("FAIL rst_tie_rsp: got %b %h expected 1 00000013", inst_rsp_valid, inst_rsp_data); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_misaligned();
    test_backpressure();
    test_reset_in_resp();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
